// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state enum, PC constants and FIFO entry type for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular queue of fetch entries with flush; push and pop may coincide when full
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q, cnt_d;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign rd_data = mem_q[rd_q];
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wr_data;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches from instruction memory and queues {pc, instr} toward decode
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_read,
  input  logic        instruction_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_count
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, count_q, count_d;
  logic full, empty, push, pop, flush;
  fetch_entry_t wr_entry, head;
  assign pop = ~empty & fetch_ready;
  assign flush = redirect_valid & (state_q != BOOT);
  // A pop in the same cycle frees the slot, so a full queue can still accept
  assign push = (state_q == RUN) & ~halt & instruction_ready & ~redirect_valid & (~full | pop);
  assign wr_entry = '{pc: pc_q, instr: instruction_read};
  always_comb begin
    state_d = halt ? HALTED : RUN;
    pc_d = flush ? (redirect_pc & PC_ALIGN_MASK) : push ? pc_q + PC_STEP : pc_q;
    count_d = count_q + {31'd0, pop};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_PC & PC_ALIGN_MASK;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      count_q <= count_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wr_data(wr_entry),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  assign instruction_addr = pc_q;
  assign fetch_valid = ~empty;
  assign fetch_instr = head.instr;
  assign fetch_pc = head.pc;
  assign fetch_count = count_q;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of `instruction_memory`. It owns the program counter and drives `instruction_addr`, samples `instruction_read` when `instruction_ready` is high, and queues `{pc, instruction}` pairs in a small FIFO toward decode with a valid/ready handshake. It also handles control-flow redirects (flush and reload PC) and a halt request that freezes fetching while decode drains the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] are ignored.
- `DEPTH`, default 2: FIFO entries; power of two, minimum 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instruction_addr`  out  32  current PC to instruction memory; always word-aligned.
- `instruction_read`  in  32  instruction word for `instruction_addr`, same cycle.
- `instruction_ready`  in  1  `instruction_read` is valid this cycle.
- `redirect_valid`  in  1  branch/jump taken; the new target is on `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] are forced to 0.
- `halt`  in  1  level; stop issuing new fetches while high.
- `fetch_valid`  out  1  FIFO head is valid.
- `fetch_ready`  in  1  decode accepts the head this cycle.
- `fetch_instr`  out  32  instruction at the FIFO head.
- `fetch_pc`  out  32  PC of the FIFO head.
- `fetch_count`  out  32  instructions handed to decode since reset; wraps modulo 2^32.

## Operation
- **State machine** with three states: BOOT, RUN, HALTED.
  - Reset forces BOOT. BOOT lasts exactly one cycle after `reset` falls, giving memory time to reload, then moves to RUN (or HALTED if `halt`=1).
  - RUN goes to HALTED when `halt`=1. HALTED goes to RUN when `halt`=0. Each transition takes effect on the next edge.
- **Pop:** `pop = fetch_valid & fetch_ready`.
- **Push condition:** `push = (state==RUN) & ~halt & instruction_ready & ~redirect_valid & (~full | pop)`.
- **On push:** the FIFO tail gets `{pc, instruction_read}` and `pc <= pc + 4`. The PC wraps at 32'hFFFF_FFFC to 0.
- **Push and pop in the same cycle:** both occur and the count is unchanged. This is legal when the FIFO is full.
- **Redirect** (any state except BOOT, highest priority):
  - FIFO is flushed (count becomes 0) and no push occurs.
  - `pc <= redirect_pc & ~3`.
  - A pop in the same cycle still counts toward `fetch_count`, because decode consumed the head.
- **Redirect during BOOT:** ignored.
- **HALTED:** the PC holds and the FIFO may drain. A redirect in HALTED updates the PC and flushes the FIFO.
- **`instruction_ready`=0:** no push and the PC holds; the same address is presented again the next cycle.
- **`fetch_count`:** increments by 1 on every pop.
- **`fetch_instr` / `fetch_pc`:** reflect the head entry and are don't-care when `fetch_valid`=0.

## Timing
- **Reset values:**
  - `instruction_addr`: `RESET_PC & ~3`
  - `fetch_valid`: 0
  - `fetch_instr`: 0
  - `fetch_pc`: 0
  - `fetch_count`: 0
  - FIFO count: 0
  - state: BOOT
- `instruction_addr` is a direct register output with no combinational path from any input.
- **Latency:** an address presented in cycle N with a push gives `fetch_valid`=1 for that entry in cycle N+1. Minimum redirect-to-valid latency is 2 cycles: flush at edge N, fetch in N+1, valid in N+2.
- **Throughput:** 1 instruction per cycle when `instruction_ready` and `fetch_ready` are both held at 1.
- **Combinational paths:** `fetch_ready` → push enable exists (pop frees a slot). There is no path to `fetch_valid`.
- **Reset asserted mid-stream:** all state clears immediately, without waiting for a clock edge.

## Structure
- **`fetch_pkg`** holds:
  - state enum `fetch_state_t` {BOOT, RUN, HALTED}
  - `PC_STEP` = 4
  - `PC_ALIGN_MASK` = 32'hFFFF_FFFC
  - packed struct `fetch_entry_t` {pc[31:0], instr[31:0]}
- **`fetch_fifo`:** one sub-module, parameterised on `DEPTH` and carrying `fetch_entry_t`. It provides push, pop, flush, full and empty, with simultaneous push and pop supported when full.

## Test plan
- **Reset and boot:** release reset with `RESET_PC`=0 and ready=1.
  - Addresses 0, 4, 8 appear from the second cycle after release.
  - `fetch_pc` sequence is 0, 4, 8; `fetch_count` increments each pop.
- **Backpressure:** set `fetch_ready`=0 for 5 cycles.
  - FIFO fills to 2 and `instruction_addr` holds at 8.
  - Then raise `fetch_ready`=1: outputs 0, 4, 8 in order with no duplicates or gaps.
- **Redirect:** assert `redirect_valid` with `redirect_pc`=32'h0000_0013 while the FIFO holds 2 entries.
  - `fetch_valid`=0 the next cycle.
  - `instruction_addr`=32'h10, and `fetch_pc`=32'h10 two cycles later.
- **Memory stall:** `instruction_ready`=0 for 3 cycles at PC 32'h0C.
  - Address stays at 32'h0C and there are no pushes.
  - On resume the entry has pc 32'h0C.
- **Halt:** `halt`=1 with 2 entries queued.
  - PC frozen, both entries drain, then `fetch_valid`=0.
  - Redirect to 32'h40 while halted, then deassert `halt`: first delivered pc is 32'h40.
- **Wrap and mid-stream reset:**
  - `RESET_PC`=32'hFFFF_FFF8: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0.
  - Assert reset asynchronously mid-cycle: all outputs return to reset values immediately.
